conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Upstream feeder for the 2x2 convolution neuron.
- Accepts a raster-order 8-bit pixel stream, one pixel per accepted cycle, and keeps one image row in a line buffer.
- Emits every stride-1 2x2 window as a packed 4-pixel vector in the neuron's pixels format, with a valid strobe.
- Sits between the image source and the convolution neuron.

Parameters:
- IMG_W, 8: pixels per image row; legal range >= 2.
- IMG_H, 8: rows per frame; legal range >= 2.
- PIX_W, 8: bits per pixel; the neuron interface fixes it at 8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in is accepted on this rising edge; gaps are allowed.
- sof  in  1  start of frame; qualified by pix_valid, marks pix_in as pixel (0,0).
- pixels  out  [3:0][PIX_W-1:0]  window: [3]=top-left, [2]=top-right, [1]=bottom-left, [0]=bottom-right.
- win_valid  out  1  pixels holds a new window this cycle; one-cycle pulse per window.
- frame_done  out  1  one-cycle pulse, same cycle as the last window of the frame.
- win_row  out  $clog2(IMG_H)  row index of the bottom-right pixel of the current window.
- win_col  out  $clog2(IMG_W)  column index of the bottom-right pixel of the current window.

Behaviour:
- Reset:
  - pixels=0, win_valid=0, frame_done=0, win_row=0, win_col=0.
  - col and row counters = 0; line buffer cleared to 0.
  - Reset overrides pix_valid in the same cycle.
- Counters:
  - col and row advance only on accepted pixels (pix_valid=1).
  - col wraps at IMG_W-1 to 0 and increments row.
  - row wraps at IMG_H-1 to 0 together with col, starting the next frame.
- sof:
  - pix_valid & sof forces the accepted pixel to be treated as (0,0).
  - The next accepted pixel becomes (0,1).
  - Any partial frame is abandoned; its pending windows are not produced.
- Line buffer:
  - IMG_W+1 entry shift register of accepted pixels; shifts only when pix_valid=1.
  - Tap 0 = previous pixel (i-1).
  - Tap IMG_W-1 = pixel above (i-W).
  - Tap IMG_W = pixel above-left (i-W-1).
- Window formation, for an accepted pixel at (row,col) with row>=1 and col>=1, on that same rising edge:
  - pixels <= {above-left, above, previous, pix_in}.
  - win_valid <= 1; win_row/win_col <= row/col.
  - Latency: outputs are registered, one cycle after the accepting edge.
- Non-windows:
  - Pixels in row 0 or column 0 produce no window; win_valid <= 0.
  - A cycle with pix_valid=0 drives win_valid <= 0.
  - pixels, win_row and win_col hold their last value whenever win_valid=0.
- Row boundary: a column-0 pixel never pairs with the previous row's last column; no wrap-around windows.
- Window count: exactly (IMG_W-1)*(IMG_H-1) windows per complete frame.
- frame_done:
  - Asserted with win_valid for the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
  - Back-to-back frames: the first pixel of the next frame may arrive the very next cycle with no bubble.
- Reset mid-frame:
  - All state returns to reset values.
  - The first accepted pixel after reset is (0,0), with or without sof.
- No backpressure: the neuron accepts a window every cycle. Source pacing is via pix_valid only.

Decomposition:
- Shared package cnn_pkg:
  - PIX_W.
  - typedef pixel_t = logic [PIX_W-1:0].
  - typedef window_t = pixel_t [3:0].
  - Window index constants WIN_TL=3, WIN_TR=2, WIN_BL=1, WIN_BR=0, shared with the neuron's kernel ordering.
- One sub-module: conv_line_buffer.
  - Parameterised shift register with enable (shift_en, din) and taps prev, above, above_left.
  - Synchronous clear on rst.
- Counters, window assembly and frame_done stay in conv_window_gen.

Test Plan (IMG_W=4, IMG_H=3 unless noted):
1. Continuous stream: pixels 0x00..0x0B, sof on first.
   - Exactly 6 win_valid pulses.
   - First window, one cycle after the 0x05 accept: pixels={00,01,04,05}, win_row=1, win_col=1.
   - Last window: {06,07,0A,0B} with frame_done=1.
2. Same frame with pix_valid=0 inserted every other cycle.
   - Identical 6 windows in the same order; win_valid never high in gap+1 cycles.
   - pixels holds its value through the gaps.
3. Two frames back to back (0x00..0x0B then 0x10..0x1B), sof on each first pixel.
   - 12 windows; frame_done pulses twice.
   - Second frame's first window is {10,11,14,15}; no window mixes the two frames.
4. sof asserted mid-frame on the 7th pixel, followed by 0x20..0x2B.
   - No window of the abandoned frame appears after the sof.
   - Next window is {20,21,24,25}.
5. rst asserted for one cycle after pixel 0x06, then 0x30..0x3B without sof.
   - Cycle after rst: all outputs 0.
   - First window is {30,31,34,35}.
6. IMG_W=2, IMG_H=2 instance, pixels 0xfb,0x05,0x05,0xfb.
   - Single window {fb,05,05,fb} with win_valid=1 and frame_done=1 on the same cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Types and constants shared between the window generator and the convolution neuron.
package cnn_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [3:0]     window_t;

  // Window slot order matches the neuron's kernel ordering.
  localparam int WIN_TL = 3;
  localparam int WIN_TR = 2;
  localparam int WIN_BL = 1;
  localparam int WIN_BR = 0;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle between image source, window generator and neuron.
interface conv_window_gen_if import cnn_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
);

  localparam int RowW = $clog2(IMG_H);
  localparam int ColW = $clog2(IMG_W);

  pixel_t          pix_in;
  logic            pix_valid;
  logic            sof;
  window_t         pixels;
  logic            win_valid;
  logic            frame_done;
  logic [RowW-1:0] win_row;
  logic [ColW-1:0] win_col;

  modport master (
    output pix_in, pix_valid, sof,
    input  pixels, win_valid, frame_done, win_row, win_col
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output pixels, win_valid, frame_done, win_row, win_col
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One-row-plus-one shift register of accepted pixels with the three taps a 2x2 window needs.
module conv_line_buffer import cnn_pkg::*; #(
  parameter int IMG_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_shift_en,
  input  pixel_t i_din,
  output pixel_t o_prev,
  output pixel_t o_above,
  output pixel_t o_above_left
);

  pixel_t r_taps [IMG_W+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= IMG_W; i++) r_taps[i] <= '0;
    end else if (i_shift_en) begin
      r_taps[0] <= i_din;
      for (int i = 1; i <= IMG_W; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  // Before the shift, tap k holds pixel i-1-k.
  assign o_prev       = r_taps[0];
  assign o_above      = r_taps[IMG_W-1];
  assign o_above_left = r_taps[IMG_W];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to stride-1 2x2 windows, with row/col tags and an end-of-frame pulse.
module conv_window_gen import cnn_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave io_bus
);

  localparam int RowW = $clog2(IMG_H);
  localparam int ColW = $clog2(IMG_W);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);

  logic [RowW-1:0] r_row;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] w_row;
  logic [ColW-1:0] w_col;
  logic            w_win;
  logic            w_last;

  pixel_t w_prev;
  pixel_t w_above;
  pixel_t w_above_left;

  window_t         r_pixels;
  logic            r_win_valid;
  logic            r_frame_done;
  logic [RowW-1:0] r_win_row;
  logic [ColW-1:0] r_win_col;

  conv_line_buffer #(
    .IMG_W (IMG_W)
  ) u_line_buffer (
    .clk          (clk),
    .rst          (rst),
    .i_shift_en   (io_bus.pix_valid),
    .i_din        (io_bus.pix_in),
    .o_prev       (w_prev),
    .o_above      (w_above),
    .o_above_left (w_above_left)
  );

  // sof relabels the incoming pixel as (0,0), abandoning any partial frame.
  always_comb begin
    w_row  = io_bus.sof ? '0 : r_row;
    w_col  = io_bus.sof ? '0 : r_col;
    w_win  = io_bus.pix_valid && (w_row != '0) && (w_col != '0);
    w_last = (w_row == RowLast) && (w_col == ColLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_pixels     <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_win_valid  <= w_win;
      r_frame_done <= w_win && w_last;
      if (io_bus.pix_valid) begin
        if (w_col == ColLast) begin
          r_col <= '0;
          r_row <= (w_row == RowLast) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
      if (w_win) begin
        r_pixels[WIN_TL] <= w_above_left;
        r_pixels[WIN_TR] <= w_above;
        r_pixels[WIN_BL] <= w_prev;
        r_pixels[WIN_BR] <= io_bus.pix_in;
        r_win_row        <= w_row;
        r_win_col        <= w_col;
      end
    end
  end

  assign io_bus.pixels     = r_pixels;
  assign io_bus.win_valid  = r_win_valid;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.win_row    = r_win_row;
  assign io_bus.win_col    = r_win_col;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: 4x3 instance against an image-array model, plus a 2x2 instance.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.IMG_W(W), .IMG_H(H)) bus ();
  conv_window_gen_if #(.IMG_W(2), .IMG_H(2)) bus2 ();

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  conv_window_gen #(.IMG_W(2), .IMG_H(2)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus2)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_win = 0;
  int n_fd  = 0;

  // Reference model: frame held as a 2-D image, position as a linear raster index.
  int          m_pos = 0;
  logic [7:0]  m_img [H][W];
  logic        exp_wv, exp_fd;
  logic [31:0] exp_pix;
  logic [1:0]  exp_row, exp_col;

  function automatic void model_step(input logic r, input logic v, input logic s,
                                     input logic [7:0] p);
    int row, col;
    if (r) begin
      m_pos = 0; exp_wv = 0; exp_fd = 0; exp_pix = '0; exp_row = '0; exp_col = '0;
      return;
    end
    exp_wv = 0;
    exp_fd = 0;
    if (!v) return;
    if (s) m_pos = 0;
    row = m_pos / W;
    col = m_pos % W;
    m_img[row][col] = p;
    if (row >= 1 && col >= 1) begin
      exp_wv  = 1;
      exp_pix = {m_img[row-1][col-1], m_img[row-1][col], m_img[row][col-1], p};
      exp_row = 2'(row);
      exp_col = 2'(col);
      exp_fd  = (m_pos == W * H - 1);
    end
    m_pos = (m_pos + 1) % (W * H);
  endfunction

  task automatic cycle(input logic r, input logic v, input logic s, input logic [7:0] p);
    rst = r; bus.pix_valid = v; bus.sof = s; bus.pix_in = p;
    @(posedge clk);
    #1;
    model_step(r, v, s, p);
    if (bus.win_valid === 1'b1) n_win++;
    if (bus.frame_done === 1'b1) n_fd++;
    rst = 1'b0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
      n_vec++;
      if ({bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col} !== '0 ||
          {bus2.win_valid, bus2.frame_done, bus2.pixels, bus2.win_row, bus2.win_col} !== '0) begin
        n_err++;
        $display("FAIL reset[%0d]: got v=%b fd=%b pix=%h r=%0d c=%0d small_pix=%h, want all 0",
                 i, bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col,
                 bus2.pixels);
      end
    end
  endtask

  // gap=1 inserts an idle cycle after every pixel.
  task automatic test_stream(input logic [7:0] base, input bit gap, input int frames);
    int w0, f0;
    w0 = n_win; f0 = n_fd;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < W * H; i++) begin
        for (int g = 0; g <= int'(gap); g++) begin
          if (g == 0) cycle(1'b0, 1'b1, i == 0, base + 8'(16 * f + i));
          else        cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
          n_vec++;
          if ({bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col} !==
              {exp_wv, exp_fd, exp_pix, exp_row, exp_col}) begin
            n_err++;
            $display("FAIL stream f%0d p%0d g%0d: got v=%b fd=%b pix=%h r=%0d c=%0d, want v=%b fd=%b pix=%h r=%0d c=%0d",
                     f, i, g, bus.win_valid, bus.frame_done, bus.pixels, bus.win_row,
                     bus.win_col, exp_wv, exp_fd, exp_pix, exp_row, exp_col);
          end
        end
      end
    end
    n_vec++;
    if (n_win - w0 != frames * (W - 1) * (H - 1) || n_fd - f0 != frames) begin
      n_err++;
      $display("FAIL stream_count: got windows=%0d frame_done=%0d, want windows=%0d frame_done=%0d",
               n_win - w0, n_fd - f0, frames * (W - 1) * (H - 1), frames);
    end
  endtask

  task automatic test_sof_mid_frame();
    for (int i = 0; i < 6 + W * H; i++) begin
      if (i < 6) cycle(1'b0, 1'b1, i == 0, 8'(i));
      else       cycle(1'b0, 1'b1, i == 6, 8'h20 + 8'(i - 6));
      n_vec++;
      if ({bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col} !==
          {exp_wv, exp_fd, exp_pix, exp_row, exp_col}) begin
        n_err++;
        $display("FAIL sof_mid p%0d: got v=%b fd=%b pix=%h r=%0d c=%0d, want v=%b fd=%b pix=%h r=%0d c=%0d",
                 i, bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col,
                 exp_wv, exp_fd, exp_pix, exp_row, exp_col);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 8 + W * H; i++) begin
      if (i < 7)       cycle(1'b0, 1'b1, i == 0, 8'(i));
      else if (i == 7) cycle(1'b1, 1'b1, 1'b0, 8'hee);
      else             cycle(1'b0, 1'b1, 1'b0, 8'h30 + 8'(i - 8));
      n_vec++;
      if ({bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col} !==
          {exp_wv, exp_fd, exp_pix, exp_row, exp_col}) begin
        n_err++;
        $display("FAIL rst_mid p%0d: got v=%b fd=%b pix=%h r=%0d c=%0d, want v=%b fd=%b pix=%h r=%0d c=%0d",
                 i, bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col,
                 exp_wv, exp_fd, exp_pix, exp_row, exp_col);
      end
    end
  endtask

  task automatic test_random();
    int f0, sent;
    f0 = n_fd;
    sent = 0;
    while (sent < 3 * W * H) begin
      if ($urandom_range(0, 2) == 0) begin
        cycle(1'b0, 1'b0, 1'($urandom), 8'($urandom));
      end else begin
        cycle(1'b0, 1'b1, (sent % (W * H) == 0) && ($urandom_range(0, 1) == 1), 8'($urandom));
        sent++;
      end
      n_vec++;
      if ({bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col} !==
          {exp_wv, exp_fd, exp_pix, exp_row, exp_col}) begin
        n_err++;
        $display("FAIL random s%0d: got v=%b fd=%b pix=%h r=%0d c=%0d, want v=%b fd=%b pix=%h r=%0d c=%0d",
                 sent, bus.win_valid, bus.frame_done, bus.pixels, bus.win_row, bus.win_col,
                 exp_wv, exp_fd, exp_pix, exp_row, exp_col);
      end
    end
    n_vec++;
    if (n_fd - f0 != 3) begin
      n_err++;
      $display("FAIL random_frames: got frame_done=%0d, want 3", n_fd - f0);
    end
  endtask

  task automatic test_tiny();
    logic [7:0] px [4];
    px[0] = 8'hfb; px[1] = 8'h05; px[2] = 8'h05; px[3] = 8'hfb;
    for (int i = 0; i < 4; i++) begin
      bus2.pix_valid = 1'b1; bus2.sof = (i == 0); bus2.pix_in = px[i];
      @(posedge clk);
      #1;
      bus2.pix_valid = 1'b0; bus2.sof = 1'b0;
      n_vec++;
      if (i < 3 && (bus2.win_valid !== 1'b0 || bus2.frame_done !== 1'b0)) begin
        n_err++;
        $display("FAIL tiny p%0d: got v=%b fd=%b, want v=0 fd=0", i, bus2.win_valid,
                 bus2.frame_done);
      end else if (i == 3 && {bus2.win_valid, bus2.frame_done, bus2.pixels, bus2.win_row,
                              bus2.win_col} !== {2'b11, 32'hfb0505fb, 2'b11}) begin
        n_err++;
        $display("FAIL tiny window: got v=%b fd=%b pix=%h r=%0d c=%0d, want v=1 fd=1 pix=fb0505fb r=1 c=1",
                 bus2.win_valid, bus2.frame_done, bus2.pixels, bus2.win_row, bus2.win_col);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.pix_in = '0;
    bus2.pix_valid = 1'b0; bus2.sof = 1'b0; bus2.pix_in = '0;
    test_reset();
    test_stream(8'h00, 1'b0, 1);
    test_stream(8'h00, 1'b1, 1);
    test_stream(8'h00, 1'b0, 2);
    test_sof_mid_frame();
    test_reset_mid_frame();
    test_random();
    test_tiny();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
